// File: rtl/main_module.sv
// Single-cycle 32-bit MIPS subset: one instruction committed per rising clock edge.
// Holds PC, instruction ROM, 32x32 register file, ALU, control decode and data RAM.
// A debug read port exposes GPR[add] on A while dis is high.
module main_module #(
    parameter int IMEM_DEPTH = 32,
    parameter int DMEM_DEPTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dis,
    input  logic [4:0]  add,
    output logic [31:0] A
);

    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);
    localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [31:0] instr;
    logic [IW-1:0] rom_idx;

    logic [31:0] gpr  [32];
    logic [31:0] dmem [DMEM_DEPTH];

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_sext;

    logic        reg_write;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
    alu_op_t     alu_op;

    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic [DW-1:0] dmem_idx;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    assign rom_idx  = pc[IW+1:2];
    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign funct    = instr[5:0];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};

    // Instruction ROM holding the default program; unlisted words are 0 (sll $0 = NOP).
    always_comb begin
        instr = 32'h0000_0000;
        case (rom_idx)
            IW'(0):  instr = 32'h2001_0005; // addi $1,$0,5
            IW'(1):  instr = 32'h2002_0003; // addi $2,$0,3
            IW'(2):  instr = 32'h0022_1820; // add  $3,$1,$2
            IW'(3):  instr = 32'h0022_2022; // sub  $4,$1,$2
            IW'(4):  instr = 32'hAC03_0000; // sw   $3,0($0)
            IW'(5):  instr = 32'h8C05_0000; // lw   $5,0($0)
            IW'(6):  instr = 32'h1021_0001; // beq  $1,$1,+1
            IW'(7):  instr = 32'h2006_0001; // addi $6,$0,1 (skipped)
            IW'(8):  instr = 32'h0800_0008; // j    8
            default: instr = 32'h0000_0000;
        endcase
    end

    // Control decode: unknown opcodes and functs fall through as NOPs.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_op     = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                reg_dst = 1'b1;
                case (funct)
                    F_ADD: begin reg_write = 1'b1; alu_op = ALU_ADD; end
                    F_SUB: begin reg_write = 1'b1; alu_op = ALU_SUB; end
                    F_AND: begin reg_write = 1'b1; alu_op = ALU_AND; end
                    F_OR:  begin reg_write = 1'b1; alu_op = ALU_OR;  end
                    F_SLT: begin reg_write = 1'b1; alu_op = ALU_SLT; end
                    default: reg_write = 1'b0;
                endcase
            end
            OP_ADDI: begin reg_write = 1'b1; alu_src = 1'b1; end
            OP_LW:   begin reg_write = 1'b1; alu_src = 1'b1; mem_to_reg = 1'b1; end
            OP_SW:   begin mem_write = 1'b1; alu_src = 1'b1; end
            OP_BEQ:  branch = 1'b1;
            OP_J:    jump = 1'b1;
            default: reg_write = 1'b0;
        endcase
    end

    assign rs_val = (rs == 5'd0) ? 32'h0 : gpr[rs];
    assign rt_val = (rt == 5'd0) ? 32'h0 : gpr[rt];
    assign alu_b  = alu_src ? imm_sext : rt_val;

    // ALU: two's-complement wrap-around, signed compare for slt.
    always_comb begin
        alu_result = rs_val + alu_b;
        case (alu_op)
            ALU_ADD: alu_result = rs_val + alu_b;
            ALU_SUB: alu_result = rs_val - alu_b;
            ALU_AND: alu_result = rs_val & alu_b;
            ALU_OR:  alu_result = rs_val | alu_b;
            ALU_SLT: alu_result = {31'b0, $signed(rs_val) < $signed(alu_b)};
            default: alu_result = rs_val + alu_b;
        endcase
    end

    assign dmem_idx = alu_result[DW+1:2];
    assign wr_addr  = reg_dst ? rd : rt;
    assign wr_data  = mem_to_reg ? dmem[dmem_idx] : alu_result;

    // Next PC: jump beats branch, branch taken only when the operands match.
    always_comb begin
        pc_plus4 = pc + 32'd4;
        pc_next  = pc_plus4;
        if (jump)
            pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (branch && (rs_val == rt_val))
            pc_next = pc_plus4 + {imm_sext[29:0], 2'b00};
    end

    // PC register, wrapping within the instruction ROM address range.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (reset)
            pc <= 32'h0;
        else
            pc <= pc_next & PC_MASK;
    end

    // Register file write port; reset clears every GPR and $0 is never written.
    always_ff @(posedge clock) begin
        // NOTE: the register file and data RAM must read zero after reset, so they are built from resettable flops rather than RAM macros.
        if (reset) begin
            for (int i = 0; i < 32; i++)
                gpr[i] <= 32'h0;
        end else if (reg_write && (wr_addr != 5'd0)) begin
            gpr[wr_addr] <= wr_data;
        end
    end

    // Data RAM write port; reset clears every word.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++)
                dmem[i] <= 32'h0;
        end else if (mem_write) begin
            dmem[dmem_idx] <= rt_val;
        end
    end

    // Debug read port, combinational so a write shows right after its edge.
    always_comb begin
        A = 32'h0;
        if (dis && (add != 5'd0))
            A = gpr[add];
    end

endmodule

// File: tb/tb_main_module.sv
// Self-checking bench for main_module: an instruction-level model of the MIPS subset
// runs alongside the DUT and every GPR is compared through the debug port each cycle.
`timescale 1ns/100ps
module tb_main_module;

    logic        clock;
    logic        reset;
    logic        dis;
    logic [4:0]  add;
    logic [31:0] A;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_no = 0;

    // Reference state: architectural registers, data memory and PC.
    logic [31:0] prog  [32];
    logic [31:0] m_reg [32];
    logic [31:0] m_mem [32];
    logic [31:0] m_pc;

    main_module dut (
        .clock (clock),
        .reset (reset),
        .dis   (dis),
        .add   (add),
        .A     (A)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = 32'h0;
            m_mem[i] = 32'h0;
        end
        m_pc = 32'h0;
    endtask

    task automatic model_write(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0)
            m_reg[r] = v;
    endtask

    // Execute one instruction from the architectural description.
    task automatic model_step();
        logic [31:0] ins, a, b, simm, ea, nxt;
        logic [5:0]  op, fn;
        ins  = prog[m_pc[6:2]];
        op   = ins[31:26];
        fn   = ins[5:0];
        a    = m_reg[ins[25:21]];
        b    = m_reg[ins[20:16]];
        simm = {{16{ins[15]}}, ins[15:0]};
        ea   = a + simm;
        nxt  = m_pc + 4;
        case (op)
            6'h00: case (fn)
                6'h20: model_write(ins[15:11], a + b);
                6'h22: model_write(ins[15:11], a - b);
                6'h24: model_write(ins[15:11], a & b);
                6'h25: model_write(ins[15:11], a | b);
                6'h2A: model_write(ins[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                default: ;
            endcase
            6'h08: model_write(ins[20:16], ea);
            6'h23: model_write(ins[20:16], m_mem[ea[6:2]]);
            6'h2B: m_mem[ea[6:2]] = b;
            6'h04: if (a == b) nxt = m_pc + 4 + (simm << 2);
            6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
            default: ;
        endcase
        m_pc = nxt % 128;
    endtask

    // Compare every GPR against the model, then confirm dis=0 blanks the port.
    task automatic compare_all();
        for (int i = 0; i < 32; i++) begin
            dis = 1'b1;
            add = 5'(i);
            #0.2;
            check($sformatf("gpr[%0d] edge %0d", i, edge_no), A, m_reg[i]);
        end
        dis = 1'b0;
        add = 5'($urandom_range(31));
        #0.2;
        check($sformatf("dis0 add=%0d edge %0d", add, edge_no), A, 32'h0);
    endtask

    // Hand-computed expectation that pins the model to the written program.
    task automatic lit(input logic [4:0] r, input logic [31:0] exp);
        dis = 1'b1;
        add = r;
        #0.2;
        check($sformatf("literal $%0d edge %0d", r, edge_no), A, exp);
        dis = 1'b0;
    endtask

    // Advance one rising edge, update the model and compare.
    task automatic tick(input logic rst);
        reset = rst;
        @(posedge clock);
        if (rst) model_reset();
        else     model_step();
        #1;
        compare_all();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) prog[i] = 32'h0;
        prog[0] = 32'h2001_0005;
        prog[1] = 32'h2002_0003;
        prog[2] = 32'h0022_1820;
        prog[3] = 32'h0022_2022;
        prog[4] = 32'hAC03_0000;
        prog[5] = 32'h8C05_0000;
        prog[6] = 32'h1021_0001;
        prog[7] = 32'h2006_0001;
        prog[8] = 32'h0800_0008;

        reset = 1'b1;
        dis   = 1'b0;
        add   = 5'd0;

        // Edge 0 under reset: everything reads zero.
        edge_no = 0;
        tick(1'b1);
        for (int r = 1; r <= 6; r++) lit(5'(r), 32'h0);

        // First run up to edge 20.
        for (int e = 1; e <= 20; e++) begin
            edge_no = e;
            tick(1'b0);
            if (e == 2) lit(5'd1, 32'd5);
            if (e == 3) lit(5'd2, 32'd3);
            if (e == 5) begin lit(5'd3, 32'd8); lit(5'd4, 32'd2); end
            if (e == 7) lit(5'd5, 32'd8);
            if (e >= 9) lit(5'd6, 32'd0);
            if (e == 20) lit(5'd0, 32'd0);
        end

        // Mid-run reset for one edge, then the program re-runs.
        edge_no = 0;
        tick(1'b1);
        for (int r = 1; r <= 6; r++) lit(5'(r), 32'h0);
        for (int e = 1; e <= 12; e++) begin
            edge_no = e;
            tick(1'b0);
            if (e == 2) lit(5'd1, 32'd5);
            if (e == 7) lit(5'd5, 32'd8);
            if (e == 12) lit(5'd6, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
